// File: rtl/pcpi_bridge_pkg.sv
// pcpi_bridge_pkg: state encoding, default parameters and sizing helper
// shared by the PCPI serial bridge and its slice register.
package pcpi_bridge_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } bridge_state_e;

  localparam int unsigned DEF_SEG_W       = 4;
  localparam int unsigned DEF_XLEN        = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 255;

  // Width of an index or counter spanning n items; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_shift_reg.sv
// seg_shift_reg: DEPTH segments of SEG_W bits, written one slice at a time
// (index 0 = least significant slice) or loaded as a whole word.
module seg_shift_reg
  import pcpi_bridge_pkg::*;
#(
  parameter int unsigned SEG_W = DEF_SEG_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      wr_en_i,
  input  logic [idx_w(DEPTH)-1:0]   wr_idx_i,
  input  logic [SEG_W-1:0]          wr_data_i,
  input  logic                      ld_en_i,
  input  logic [SEG_W*DEPTH-1:0]    ld_data_i,
  output logic [SEG_W*DEPTH-1:0]    data_o
);

  logic [SEG_W*DEPTH-1:0] data_q;

  // Capture a whole word or a single slice.
  // NOTE: this storage has no reset on purpose; it is always fully written
  // before anything downstream looks at it, so resetting it buys nothing.
  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (ld_en_i) begin
      data_q <= ld_data_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i*SEG_W +: SEG_W] <= wr_data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pcpi_serial_bridge.sv
// pcpi_serial_bridge: collects insn/rs1/rs2 from a narrow host stream,
// issues one PCPI request, and streams the PCPI result back LSB-first.
// Optional feature: define PCPI_TIMEOUT_EN to abandon a request after
// TIMEOUT_CYC cycles without pcpi_ready and flag it on err.
module pcpi_serial_bridge
  import pcpi_bridge_pkg::*;
#(
  parameter int unsigned SEG_W       = DEF_SEG_W,
  parameter int unsigned XLEN        = DEF_XLEN,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [SEG_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SEG_W-1:0] out_data,
  input  logic             out_ready,
  output logic             pcpi_valid,
  output logic [XLEN-1:0]  pcpi_insn,
  output logic [XLEN-1:0]  pcpi_rs1,
  output logic [XLEN-1:0]  pcpi_rs2,
  input  logic             pcpi_ready,
  input  logic             pcpi_wr,
  input  logic [XLEN-1:0]  pcpi_rd,
  output logic             done,
  output logic             err
);

  localparam int unsigned LOAD_BEATS  = 3 * XLEN / SEG_W;
  localparam int unsigned DRAIN_BEATS = XLEN / SEG_W;
  localparam int unsigned CNT_W       = idx_w(LOAD_BEATS);
  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_BEATS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_BEATS - 1);

  // Segments must tile the word exactly and a zero timeout is meaningless.
  if (((XLEN % SEG_W) != 0) || (TIMEOUT_CYC == 0)) begin : g_bad_cfg
    $error("pcpi_serial_bridge: XLEN must be a multiple of SEG_W and TIMEOUT_CYC nonzero");
  end

  bridge_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               load_we, res_ld, tmo_hit;
  logic [3*XLEN-1:0]  opnd;
  logic [XLEN-1:0]    res;

  // Operand buffer: insn in the low word, then rs1, then rs2.
  seg_shift_reg #(.SEG_W(SEG_W), .DEPTH(LOAD_BEATS)) u_load (
    .clk       (clk),
    .wr_en_i   (load_we),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .data_o    (opnd)
  );

  // Result buffer: captured whole from pcpi_rd, read back slice by slice.
  seg_shift_reg #(.SEG_W(SEG_W), .DEPTH(DRAIN_BEATS)) u_drain (
    .clk       (clk),
    .wr_en_i   (1'b0),
    .wr_idx_i  ('0),
    .wr_data_i ('0),
    .ld_en_i   (res_ld),
    .ld_data_i (pcpi_rd),
    .data_o    (res)
  );

  assign pcpi_insn = opnd[XLEN-1:0];
  assign pcpi_rs1  = opnd[2*XLEN-1:XLEN];
  assign pcpi_rs2  = opnd[3*XLEN-1:2*XLEN];
  assign out_data  = res[cnt_q*SEG_W +: SEG_W];
  assign done      = done_q;

`ifdef PCPI_TIMEOUT_EN
  localparam int unsigned TMO_W = idx_w(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // The request expires on its TIMEOUT_CYC-th cycle unless pcpi_ready arrives.
  assign tmo_hit = (state_q == ISSUE) && !pcpi_ready && (tmo_q == TMO_LAST);

  // Count waiting cycles; err is set on expiry and cleared by the next load.
  always_comb begin
    tmo_d = '0;
    if ((state_q == ISSUE) && !pcpi_ready && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
    err_d = err_q;
    if (tmo_hit) begin
      err_d = 1'b1;
    end else if (in_valid && in_ready) begin
      err_d = 1'b0;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State, shared beat counter and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state, handshake outputs and buffer write strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // fall through and leave a latch behind.
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load_we    = 1'b0;
    res_ld     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    pcpi_valid = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        pcpi_valid = 1'b1;
        if (pcpi_ready) begin
          if (pcpi_wr) begin
            res_ld  = 1'b1;
            state_d = DRAIN;
          end else begin
            done_d  = 1'b1;
            state_d = LOAD;
          end
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          state_d = LOAD;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_pcpi_serial_bridge.sv
// tb_pcpi_serial_bridge: drives a 4-bit-segment and an 8-bit-segment bridge
// from one host/PCPI model; a select bit routes traffic to one of them.
module tb_pcpi_serial_bridge;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        sel8;
  int          seg_w;
  int          n_checks;
  int          n_errors;

  logic        a_in_ready, a_out_valid, a_pcpi_valid, a_done, a_err;
  logic [3:0]  a_out_data;
  logic [31:0] a_insn, a_rs1, a_rs2;
  logic        b_in_ready, b_out_valid, b_pcpi_valid, b_done, b_err;
  logic [7:0]  b_out_data;
  logic [31:0] b_insn, b_rs1, b_rs2;

  logic        in_ready, out_valid, pcpi_valid, done, err;
  logic [7:0]  out_data;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;

  assign in_ready   = sel8 ? b_in_ready   : a_in_ready;
  assign out_valid  = sel8 ? b_out_valid  : a_out_valid;
  assign pcpi_valid = sel8 ? b_pcpi_valid : a_pcpi_valid;
  assign done       = sel8 ? b_done       : a_done;
  assign err        = sel8 ? b_err        : a_err;
  assign out_data   = sel8 ? b_out_data   : {4'h0, a_out_data};
  assign pcpi_insn  = sel8 ? b_insn       : a_insn;
  assign pcpi_rs1   = sel8 ? b_rs1        : a_rs1;
  assign pcpi_rs2   = sel8 ? b_rs2        : a_rs2;

  always #5 clk = ~clk;

  pcpi_serial_bridge #(.SEG_W(4), .XLEN(32), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel8), .in_data(in_data[3:0]), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready && !sel8),
    .pcpi_valid(a_pcpi_valid), .pcpi_insn(a_insn), .pcpi_rs1(a_rs1), .pcpi_rs2(a_rs2),
    .pcpi_ready(pcpi_ready && !sel8), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .done(a_done), .err(a_err)
  );

  pcpi_serial_bridge #(.SEG_W(8), .XLEN(32), .TIMEOUT_CYC(TMO)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel8), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready && sel8),
    .pcpi_valid(b_pcpi_valid), .pcpi_insn(b_insn), .pcpi_rs1(b_rs1), .pcpi_rs2(b_rs2),
    .pcpi_ready(pcpi_ready && sel8), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .done(b_done), .err(b_err)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    bit          wr;
    int          lat;
    bit          long_stall;
    bit          seg8;
    logic [31:0] exp_result;
    int          exp_segs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] seg_mask();
    return (seg_w == 8) ? 32'hFF : 32'hF;
  endfunction

  // Send the first nbeats segments of {rs2, rs1, insn}, LSB-first, with random gaps.
  task automatic load_words(input logic [31:0] insn, input logic [31:0] rs1,
                            input logic [31:0] rs2, input int nbeats);
    logic [95:0] all;
    logic [95:0] sh;
    int          total;
    all   = {rs2, rs1, insn};
    total = 96 / seg_w;
    for (int k = 0; k < nbeats; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      check_bit("load_in_ready", in_ready, 1'b1);
      if (k == total - 1) check_bit("early_issue", pcpi_valid, 1'b0);
      sh       = all >> (k * seg_w);
      in_valid = 1'b1;
      in_data  = 8'(sh[31:0] & seg_mask());
      @(negedge clk);
      if (k == 0) check_bit("err_clear", err, 1'b0);
    end
    in_valid = 1'b0;
  endtask

  // Hold the request for lat cycles (with ignored host traffic), then answer it.
  task automatic issue_resp(input logic [31:0] insn, input logic [31:0] rs1,
                            input logic [31:0] rs2, input int lat, input bit wr,
                            input logic [31:0] rd);
    check_bit("issue_valid", pcpi_valid, 1'b1);
    check("issue_insn", pcpi_insn, insn);
    check("issue_rs1", pcpi_rs1, rs1);
    check("issue_rs2", pcpi_rs2, rs2);
    check_bit("issue_in_ready", in_ready, 1'b0);
    for (int i = 0; i < lat; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      check_bit("issue_hold", pcpi_valid, 1'b1);
      check_bit("issue_no_out", out_valid, 1'b0);
    end
    check("issue_insn_stable", pcpi_insn, insn);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    @(negedge clk);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'($urandom);
    pcpi_rd    = $urandom;
    in_valid   = 1'b0;
    check_bit("resp_pcpi_drop", pcpi_valid, 1'b0);
    check_bit("resp_out_valid", out_valid, wr);
    check_bit("resp_done", done, !wr);
    check_bit("resp_in_ready", in_ready, !wr);
    if (!wr) begin
      @(negedge clk);
      check_bit("done_single", done, 1'b0);
    end
  endtask

  // Accept nseg result segments with random backpressure; check each slice.
  task automatic drain(input logic [31:0] exp_rd, input bit long_stall, input int nseg);
    int          total;
    int          k;
    int          guard;
    logic [31:0] acc;
    logic [31:0] exp_seg;
    total = 32 / seg_w;
    k     = 0;
    guard = 0;
    acc   = '0;
    if (long_stall) begin
      for (int i = 0; i < 10; i++) begin
        out_ready = 1'b0;
        check_bit("stall_valid", out_valid, 1'b1);
        check("stall_data", 32'(out_data), exp_rd & seg_mask());
        @(negedge clk);
      end
    end
    while (k < nseg && guard < 500) begin
      guard++;
      out_ready = ($urandom_range(0, 2) != 0);
      exp_seg   = (exp_rd >> (k * seg_w)) & seg_mask();
      check_bit("drain_valid", out_valid, 1'b1);
      check("drain_seg", 32'(out_data), exp_seg);
      if (out_ready) begin
        acc = acc | (32'(out_data) << (k * seg_w));
        k++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_count", k, nseg);
    if (nseg == total) begin
      check("result", acc, exp_rd);
      check_bit("drain_done", done, 1'b1);
      check_bit("drain_out_idle", out_valid, 1'b0);
      check_bit("drain_in_ready", in_ready, 1'b1);
      @(negedge clk);
      check_bit("done_single", done, 1'b0);
    end
  endtask

  task automatic run_txn(input vec_t v);
    sel8  = v.seg8;
    seg_w = v.seg8 ? 8 : 4;
    load_words(v.insn, v.rs1, v.rs2, 96 / seg_w);
    issue_resp(v.insn, v.rs1, v.rs2, v.lat, v.wr, v.rd);
    if (v.exp_segs > 0) drain(v.exp_result, v.long_stall, v.exp_segs);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int   n;
    n_checks   = 0;
    n_errors   = 0;
    sel8       = 1'b0;
    seg_w      = 4;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;

    vecs[0] = '{insn: 32'h0200_00B3, rs1: 32'd5, rs2: 32'd7, rd: 32'd35, wr: 1'b1, lat: 3,
                long_stall: 1'b0, seg8: 1'b0, exp_result: 32'd35, exp_segs: 8};
    vecs[1] = '{insn: 32'h0200_00B3, rs1: 32'd5, rs2: 32'd7, rd: 32'd35, wr: 1'b1, lat: 2,
                long_stall: 1'b1, seg8: 1'b0, exp_result: 32'd35, exp_segs: 8};
    vecs[2] = '{insn: 32'h1234_5678, rs1: 32'h9ABC_DEF0, rs2: 32'h0F1E_2D3C, rd: 32'hFFFF_FFFF,
                wr: 1'b0, lat: 0, long_stall: 1'b0, seg8: 1'b0, exp_result: 32'd0, exp_segs: 0};
    vecs[3] = '{insn: 32'h0200_00B3, rs1: 32'd5, rs2: 32'd7, rd: 32'd35, wr: 1'b1, lat: 3,
                long_stall: 1'b0, seg8: 1'b1, exp_result: 32'd35, exp_segs: 4};
    vecs[4] = '{insn: 32'hFFFF_FFFF, rs1: 32'h0000_0000, rs2: 32'h8000_0001, rd: 32'hA5C3_F00F,
                wr: 1'b1, lat: 1, long_stall: 1'b0, seg8: 1'b0, exp_result: 32'hA5C3_F00F, exp_segs: 8};
    vecs[5] = '{insn: 32'hCAFE_F00D, rs1: 32'h7FFF_FFFF, rs2: 32'h0000_FFFF, rd: 32'hDEAD_BEEF,
                wr: 1'b1, lat: 4, long_stall: 1'b1, seg8: 1'b1, exp_result: 32'hDEAD_BEEF, exp_segs: 4};

    // Reset state of both bridges.
    repeat (3) @(negedge clk);
    check_bit("rst_a_in_ready", a_in_ready, 1'b1);
    check_bit("rst_a_out_valid", a_out_valid, 1'b0);
    check_bit("rst_a_pcpi_valid", a_pcpi_valid, 1'b0);
    check_bit("rst_a_done", a_done, 1'b0);
    check_bit("rst_a_err", a_err, 1'b0);
    check_bit("rst_b_in_ready", b_in_ready, 1'b1);
    check_bit("rst_b_out_valid", b_out_valid, 1'b0);
    check_bit("rst_b_pcpi_valid", b_pcpi_valid, 1'b0);
    check_bit("rst_b_done", b_done, 1'b0);
    check_bit("rst_b_err", b_err, 1'b0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset after 10 of 24 load beats, then a clean load must start at bit 0.
    sel8  = 1'b0;
    seg_w = 4;
    load_words(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_bit("rst_load_in_ready", in_ready, 1'b1);
    check_bit("rst_load_pcpi_valid", pcpi_valid, 1'b0);
    check_bit("rst_load_done", done, 1'b0);
    run_txn(vecs[0]);

    // Reset in the middle of a drain, then a full transaction again.
    load_words(vecs[4].insn, vecs[4].rs1, vecs[4].rs2, 24);
    issue_resp(vecs[4].insn, vecs[4].rs1, vecs[4].rs2, 0, 1'b1, vecs[4].rd);
    drain(vecs[4].rd, 1'b0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_bit("rst_drain_out_valid", out_valid, 1'b0);
    check_bit("rst_drain_in_ready", in_ready, 1'b1);
    check_bit("rst_drain_done", done, 1'b0);
    run_txn(vecs[4]);

    // Request that pcpi never answers.
    load_words(32'h0000_0033, 32'd1, 32'd2, 24);
`ifdef PCPI_TIMEOUT_EN
    n = 0;
    while (pcpi_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check_bit("timeout_err", err, 1'b1);
    check_bit("timeout_done", done, 1'b1);
    check_bit("timeout_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check_bit("timeout_done_single", done, 1'b0);
    check_bit("timeout_err_sticky", err, 1'b1);
    run_txn(vecs[0]);
    check_bit("timeout_err_cleared", err, 1'b0);
`else
    n = 40;
    issue_resp(32'h0000_0033, 32'd1, 32'd2, n, 1'b0, 32'd0);
    check_bit("no_timeout_err", err, 1'b0);
`endif

    // Randomized transactions against the reference model.
    for (int i = 0; i < 20; i++) begin
      v.insn       = $urandom;
      v.rs1        = $urandom;
      v.rs2        = $urandom;
      v.rd         = $urandom;
      v.wr         = ($urandom_range(0, 3) != 0);
      v.lat        = $urandom_range(0, 6);
      v.long_stall = 1'b0;
      v.seg8       = 1'($urandom_range(0, 1));
      v.exp_result = v.rd;
      v.exp_segs   = v.wr ? (32 / (v.seg8 ? 8 : 4)) : 0;
      run_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcpi_serial_bridge.md
PCPI_SERIAL_BRIDGE -- requirements
Module: pcpi_serial_bridge

Interface
REQ-001 SHALL have parameter SEG_W, default 4: width of one host segment in bits.
REQ-002 SHALL have parameter XLEN, default 32: PCPI word width in bits; XLEN % SEG_W == 0.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles spent waiting for pcpi_ready.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  in  1  host segment valid.
REQ-007 SHALL have port in_data  in  SEG_W  host segment payload.
REQ-008 SHALL have port in_ready  out  1  bridge accepts segment.
REQ-009 SHALL have port out_valid  out  1  result segment valid.
REQ-010 SHALL have port out_data  out  SEG_W  result segment payload.
REQ-011 SHALL have port out_ready  in  1  host accepts result segment.
REQ-012 SHALL have ports pcpi_valid out 1, pcpi_insn out XLEN, pcpi_rs1 out XLEN, pcpi_rs2 out XLEN: PCPI request.
REQ-013 SHALL have ports pcpi_ready in 1, pcpi_wr in 1, pcpi_rd in XLEN: PCPI response.
REQ-014 SHALL have ports done out 1 (one-cycle completion pulse) and err out 1 (timeout sticky flag).

Function
REQ-015 SHALL implement states LOAD, ISSUE, DRAIN; a segment transfers when valid && ready in the same cycle.
REQ-016 In LOAD, in_ready SHALL be 1; each accepted segment writes the next SEG_W slice, LSB-first, in order insn, rs1, rs2 (3*XLEN/SEG_W beats; 24 at defaults).
REQ-017 Beat counter SHALL wrap to 0 after the last rs2 segment, and state SHALL go LOAD->ISSUE on that beat.
REQ-018 In ISSUE, pcpi_valid SHALL be 1 and insn/rs1/rs2 SHALL stay stable until pcpi_ready is sampled high.
REQ-019 On pcpi_ready && pcpi_wr: latch pcpi_rd, drop pcpi_valid next cycle, go ISSUE->DRAIN.
REQ-020 On pcpi_ready && !pcpi_wr: drop pcpi_valid, pulse done, go ISSUE->LOAD; no result segments emitted.
REQ-021 In DRAIN, out_valid SHALL be 1, out_data = current result slice LSB-first; out_data stable while out_valid && !out_ready.
REQ-022 After the XLEN/SEG_W-th accepted result segment: pulse done, go DRAIN->LOAD.
REQ-023 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside DRAIN; in_valid outside LOAD SHALL be ignored.
REQ-024 err SHALL clear on the first segment accepted in LOAD.
REQ-025 done SHALL never be high two consecutive cycles.

Reset
REQ-026 rst_n low at a clock edge SHALL force state LOAD, counters 0, pcpi_valid 0, out_valid 0, done 0, err 0, from any state including mid-load and mid-drain.
REQ-027 Latched insn/rs1/rs2/result registers SHALL need no reset; outputs derived from them are don't-care until written.

Configuration
REQ-028 With PCPI_TIMEOUT_EN defined: ISSUE SHALL count cycles; reaching TIMEOUT_CYC without pcpi_ready SHALL drop pcpi_valid, set err, pulse done, go to LOAD.
REQ-029 Without PCPI_TIMEOUT_EN: ISSUE SHALL wait indefinitely; err SHALL be tied 0; no timeout counter logic.

Structure
REQ-030 Shared package pcpi_bridge_pkg SHALL hold the state enum and default parameter constants.
REQ-031 Sub-module seg_shift_reg (parametrised width/depth slice writer with LSB-first index) SHALL be used for load and drain.

Verification
REQ-032 Defaults: load insn 0x0200_00B3, rs1 5, rs2 7; pcpi_ready+wr 3 cycles later with rd 35 -> out segments 3,2,0,0,0,0,0,0, then done.
REQ-033 out_ready held low 10 cycles in DRAIN -> out_data remains 0x3 and out_valid stays 1.
REQ-034 pcpi_ready with pcpi_wr 0 -> no out_valid, done pulse, in_ready 1 next cycle.
REQ-035 PCPI_TIMEOUT_EN, TIMEOUT_CYC 16, pcpi_ready never -> pcpi_valid drops after 16 cycles, err 1, done pulse; next load clears err.
REQ-036 rst_n low after 10 of 24 load beats -> next 24 beats load a fresh instruction starting at insn bit 0.
REQ-037 SEG_W 8 -> 12 load beats, 4 drain beats, same rd value reconstructed.
